// File: rtl/tick_counter.sv
`default_nettype none
// ============================================================================
// Module  : tick_counter (with CarrySelectAdder)
// Brief   : Registered modulo counter with per-period tick, one-shot/continuous
//           modes. Optional wrap counter port enabled by TICK_COUNTER_WRAP_CNT_EN.
// Revision: 1.0
// ============================================================================

module CarrySelectAdder #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    generate
        if (WIDTH < 2) begin : g_single
            logic [WIDTH:0] w_full;
            assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
            assign o_sum  = w_full[WIDTH-1:0];
            assign o_cout = w_full[WIDTH];
        end else begin : g_split
            localparam int LO = WIDTH / 2;
            localparam int HI = WIDTH - LO;
            logic [LO:0] w_lo;
            logic [HI:0] w_hi0;
            logic [HI:0] w_hi1;
            assign w_lo  = {1'b0, i_a[LO-1:0]} + {1'b0, i_b[LO-1:0]} + {{LO{1'b0}}, i_cin};
            // Upper half precomputed for both carry-in values; low carry selects.
            assign w_hi0 = {1'b0, i_a[WIDTH-1:LO]} + {1'b0, i_b[WIDTH-1:LO]};
            assign w_hi1 = {1'b0, i_a[WIDTH-1:LO]} + {1'b0, i_b[WIDTH-1:LO]} + {{HI{1'b0}}, 1'b1};
            assign o_sum  = w_lo[LO] ? {w_hi1[HI-1:0], w_lo[LO-1:0]} : {w_hi0[HI-1:0], w_lo[LO-1:0]};
            assign o_cout = w_lo[LO] ? w_hi1[HI] : w_hi0[HI];
        end
    endgenerate
endmodule

module tick_counter #(
    parameter int BITS = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            start,
    input  logic            stop,
    input  logic            one_shot,
    input  logic            en,
    input  logic [BITS-1:0] limit,
    output logic [BITS-1:0] count,
    output logic            tick,
    output logic            busy,
`ifdef TICK_COUNTER_WRAP_CNT_EN
    output logic            done,
    output logic [7:0]      wraps
`else
    output logic            done
`endif
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [BITS-1:0] r_count, w_count_nxt;
    logic [BITS-1:0] r_limit_q, w_limit_nxt;
    logic            r_mode_q, w_mode_nxt;
    logic            r_tick, w_tick_nxt;
    logic            r_busy;
    logic            r_done, w_done_nxt;
    logic            w_wrap;
    logic [BITS-1:0] w_sum;
    logic            w_cout_unused;

    CarrySelectAdder #(.WIDTH(BITS)) u_adder (
        .i_a    (r_count),
        .i_b    ({BITS{1'b0}}),
        .i_cin  (1'b1),
        .o_sum  (w_sum),
        .o_cout (w_cout_unused)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_limit_nxt = r_limit_q;
        w_mode_nxt  = r_mode_q;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = r_done;
        w_wrap      = 1'b0;
        if (clear || stop) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
            w_done_nxt  = 1'b0;
        end else if (start) begin
            // Same path restarts a live run or re-arms after a one-shot.
            w_state_nxt = S_RUN;
            w_count_nxt = '0;
            w_done_nxt  = 1'b0;
            w_limit_nxt = limit;
            w_mode_nxt  = one_shot;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (en) begin
                        if (r_count == r_limit_q) begin
                            w_count_nxt = '0;
                            w_tick_nxt  = 1'b1;
                            w_wrap      = 1'b1;
                            if (r_mode_q) begin
                                w_state_nxt = S_DONE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_count_nxt = w_sum;
                        end
                    end
                end
                S_DONE:  w_count_nxt = '0;
                default: w_count_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_limit_q <= '0;
            r_mode_q  <= 1'b0;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_limit_q <= w_limit_nxt;
            r_mode_q  <= w_mode_nxt;
            r_tick    <= w_tick_nxt;
            r_busy    <= (w_state_nxt == S_RUN);
            r_done    <= w_done_nxt;
        end
    end

`ifdef TICK_COUNTER_WRAP_CNT_EN
    localparam logic [7:0] c_WRAP_MAX = 8'd255;
    logic [7:0] r_wraps;

    always_ff @(posedge clk) begin
        if (reset || clear || start) begin
            r_wraps <= 8'd0;
        end else if (w_wrap && (r_wraps != c_WRAP_MAX)) begin
            r_wraps <= r_wraps + 8'd1;
        end
    end

    assign wraps = r_wraps;
`else
    logic w_wrap_unused;
    assign w_wrap_unused = w_wrap;
`endif

    assign count = r_count;
    assign tick  = r_tick;
    assign busy  = r_busy;
    assign done  = r_done;
endmodule

`default_nettype wire
